tracer_udma_rx_ch: RTL and testbench

- uDMA RX channel engine that consumes the configuration state produced by the tracer register interface.
- Accepts trace beats from the trace encoder over a valid/ready stream and writes them into L2 over a req/gnt port.
- Tracks current address and remaining bytes, and reports en/pending/curr_addr/bytes_left back for register readback.
- Supports one queued (pending) transfer and continuous re-arm.

---
 rtl/tracer_rx_pkg.sv | 40 ++++
 rtl/tracer_rx_lane_align.sv | 35 +++
 rtl/tracer_udma_rx_ch.sv | 223 ++++++++++++++++++++++
 tb/tb_tracer_udma_rx_ch.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_rx_pkg.sv
// Shared types and helpers for the tracer uDMA RX channel.
package tracer_rx_pkg;

   // Beat size encoding as programmed by the register interface (3 also means word).
   typedef enum logic [1:0] {
      DS_BYTE = 2'd0,
      DS_HALF = 2'd1,
      DS_WORD = 2'd2
   } datasize_e;

   // Channel engine states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   // Map the raw register field onto the enum, folding the spare code onto word.
   function automatic datasize_e decode_datasize(input logic [1:0] raw);
      datasize_e ds;
      case (raw)
         2'd0:    ds = DS_BYTE;
         2'd1:    ds = DS_HALF;
         default: ds = DS_WORD;
      endcase
      return ds;
   endfunction

   // Number of bytes one beat occupies in L2.
   function automatic logic [2:0] bytes_per_beat(input datasize_e ds);
      logic [2:0] n;
      case (ds)
         DS_BYTE: n = 3'd1;
         DS_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tracer_rx_lane_align.sv
// Places an LSB-aligned trace beat onto the 32-bit L2 write lanes:
// replicates narrow beats across all lanes and selects the byte enables
// from the low address bits.
module tracer_rx_lane_align
   import tracer_rx_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  datasize_e   datasize_i,
   input  logic [31:0] data_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o
);

   // Byte enables and replicated write data for the current beat size.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      be_o    = 4'hF;
      wdata_o = data_i;
      case (datasize_i)
         DS_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{data_i[7:0]}};
         end
         DS_HALF: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{data_i[15:0]}};
         end
         default: begin
            be_o    = 4'hF;
            wdata_o = data_i;
         end
      endcase
   end

endmodule

// File: rtl/tracer_udma_rx_ch.sv
// tracer_udma_rx_ch: uDMA RX channel engine. Takes trace beats over a
// valid/ready stream, buffers one beat and writes it to L2 over req/gnt,
// tracking address and remaining bytes, with one queued transfer and
// continuous re-arm.
// Optional build macro TRACER_RX_DROP_CNT_EN adds drop_cnt_o, a saturating
// count of beats discarded while the channel is idle.
module tracer_udma_rx_ch
   import tracer_rx_pkg::*;
#(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
   input  logic [TRANS_SIZE-1:0]     cfg_size_i,
   input  logic [1:0]                cfg_datasize_i,
   input  logic                      cfg_continuous_i,
   input  logic                      cfg_en_i,
   input  logic                      cfg_clr_i,
   output logic                      cfg_en_o,
   output logic                      cfg_pending_o,
   output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
   output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
   input  logic [31:0]               data_i,
   input  logic                      data_valid_i,
   output logic                      data_ready_o,
   output logic                      l2_req_o,
   input  logic                      l2_gnt_i,
   output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
   output logic [31:0]               l2_wdata_o,
   output logic [3:0]                l2_be_o,
`ifdef TRACER_RX_DROP_CNT_EN
   output logic                      eot_o,
   output logic [15:0]               drop_cnt_o
`else
   output logic                      eot_o
`endif
);

   state_e                    state_q;
   logic [L2_AWIDTH_NOAL-1:0] curr_addr_q;
   logic [TRANS_SIZE-1:0]     bytes_left_q;
   datasize_e                 ds_q;
   logic                      cont_q;
   logic                      buf_valid_q;
   logic [31:0]               buf_data_q;
   logic                      pending_q;
   logic [L2_AWIDTH_NOAL-1:0] sh_addr_q;
   logic [TRANS_SIZE-1:0]     sh_size_q;
   datasize_e                 sh_ds_q;
   logic                      sh_cont_q;

   logic [2:0]                bsz;
   logic [L2_AWIDTH_NOAL-1:0] bsz_addr;
   logic [TRANS_SIZE-1:0]     bsz_cnt;
   logic [TRANS_SIZE-1:0]     bytes_next;
   logic                      grant_beat;
   logic                      last_beat;
   logic                      start_ok;
   logic                      rearm;
   logic                      finish;
   logic                      accept;
   logic [3:0]                lane_be;
   logic [31:0]               lane_wdata;

   assign bsz        = bytes_per_beat(ds_q);
   assign bsz_addr   = L2_AWIDTH_NOAL'(bsz);
   assign bsz_cnt    = TRANS_SIZE'(bsz);
   assign bytes_next = (bytes_left_q > bsz_cnt) ? (bytes_left_q - bsz_cnt) : '0;

   // A clear in the same cycle suppresses both the grant bookkeeping and any start.
   assign grant_beat = (state_q == ST_ACTIVE) && buf_valid_q && l2_gnt_i && !cfg_clr_i;
   assign last_beat  = grant_beat && (bytes_left_q <= bsz_cnt);
   assign start_ok   = cfg_en_i && !cfg_clr_i && (cfg_size_i != '0);
   assign rearm      = pending_q || start_ok || (cont_q && (cfg_size_i != '0));
   assign finish     = last_beat && !rearm;
   assign accept     = data_valid_i && data_ready_o;

   // Back-pressure: never stall in IDLE, one-entry buffer in ACTIVE, closed while draining.
   always_comb begin
      data_ready_o = 1'b0;
      case (state_q)
         ST_IDLE:   data_ready_o = rst_ni;   // held low while reset is asserted
         ST_ACTIVE: data_ready_o = !buf_valid_q || l2_gnt_i;
         default:   data_ready_o = 1'b0;
      endcase
   end

   tracer_rx_lane_align u_lane_align (
      .addr_lo_i  (curr_addr_q[1:0]),
      .datasize_i (ds_q),
      .data_i     (buf_data_q),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata)
   );

   // The buffered beat is always the one destined for curr_addr.
   assign l2_req_o         = buf_valid_q;
   assign l2_addr_o        = {curr_addr_q[L2_AWIDTH_NOAL-1:2], 2'b00};
   assign l2_be_o          = buf_valid_q ? lane_be : 4'h0;
   assign l2_wdata_o       = lane_wdata;
   assign eot_o            = last_beat;
   assign cfg_en_o         = (state_q == ST_ACTIVE);
   assign cfg_pending_o    = pending_q;
   assign cfg_curr_addr_o  = curr_addr_q;
   assign cfg_bytes_left_o = bytes_left_q;

   // Channel FSM with address/byte counters, beat buffer and pending shadow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the beat buffer is a plain register, so it is cleared with
         // everything else; reset also drops an outstanding request at once.
         state_q      <= ST_IDLE;
         curr_addr_q  <= '0;
         bytes_left_q <= '0;
         ds_q         <= DS_BYTE;
         cont_q       <= 1'b0;
         buf_valid_q  <= 1'b0;
         buf_data_q   <= '0;
         pending_q    <= 1'b0;
         sh_addr_q    <= '0;
         sh_size_q    <= '0;
         sh_ds_q      <= DS_BYTE;
         sh_cont_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; later assignments in this block
         // deliberately override earlier ones (reload beats the increment).
         case (state_q)
            ST_IDLE: begin
               buf_valid_q <= 1'b0;
               if (start_ok) begin
                  curr_addr_q  <= cfg_startaddr_i;
                  bytes_left_q <= cfg_size_i;
                  ds_q         <= decode_datasize(cfg_datasize_i);
                  cont_q       <= cfg_continuous_i;
                  state_q      <= ST_ACTIVE;
               end
            end

            ST_ACTIVE: begin
               if (cfg_clr_i) begin
                  pending_q    <= 1'b0;
                  bytes_left_q <= '0;
                  if (buf_valid_q && !l2_gnt_i) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     buf_valid_q <= 1'b0;
                     state_q     <= ST_IDLE;
                  end
               end else begin
                  if (grant_beat) begin
                     curr_addr_q  <= curr_addr_q + bsz_addr;
                     bytes_left_q <= bytes_next;
                  end

                  if (last_beat) begin
                     if (pending_q) begin
                        curr_addr_q  <= sh_addr_q;
                        bytes_left_q <= sh_size_q;
                        ds_q         <= sh_ds_q;
                        cont_q       <= sh_cont_q;
                        pending_q    <= 1'b0;
                     end else if (start_ok) begin
                        curr_addr_q  <= cfg_startaddr_i;
                        bytes_left_q <= cfg_size_i;
                        ds_q         <= decode_datasize(cfg_datasize_i);
                        cont_q       <= cfg_continuous_i;
                     end else if (cont_q && (cfg_size_i != '0)) begin
                        curr_addr_q  <= cfg_startaddr_i;
                        bytes_left_q <= cfg_size_i;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end else if (start_ok && !pending_q) begin
                     sh_addr_q <= cfg_startaddr_i;
                     sh_size_q <= cfg_size_i;
                     sh_ds_q   <= decode_datasize(cfg_datasize_i);
                     sh_cont_q <= cfg_continuous_i;
                     pending_q <= 1'b1;
                  end

                  // A beat taken on a final grant that ends the channel is discarded.
                  if (accept && !finish) begin
                     buf_valid_q <= 1'b1;
                     buf_data_q  <= data_i;
                  end else if (grant_beat) begin
                     buf_valid_q <= 1'b0;
                  end
               end
            end

            ST_DRAIN: begin
               // Counters stay untouched on the draining grant.
               if (l2_gnt_i) begin
                  buf_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef TRACER_RX_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   // Saturating count of beats thrown away while idle; a clear resets it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_q <= '0;
      end else if (cfg_clr_i) begin
         drop_cnt_q <= '0;
      end else if ((state_q == ST_IDLE) && data_valid_i && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tracer_udma_rx_ch.sv
// Self-checking bench for tracer_udma_rx_ch. Expected L2 writes are queued
// when a transfer is set up and checked as each granted write appears.
module tb_tracer_udma_rx_ch;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [11:0] cfg_startaddr_i = '0;
   logic [15:0] cfg_size_i = '0;
   logic [1:0]  cfg_datasize_i = '0;
   logic        cfg_continuous_i = 1'b0;
   logic        cfg_en_i = 1'b0;
   logic        cfg_clr_i = 1'b0;
   logic        cfg_en_o;
   logic        cfg_pending_o;
   logic [11:0] cfg_curr_addr_o;
   logic [15:0] cfg_bytes_left_o;
   logic [31:0] data_i = '0;
   logic        data_valid_i = 1'b0;
   logic        data_ready_o;
   logic        l2_req_o;
   logic        l2_gnt_i;
   logic [11:0] l2_addr_o;
   logic [31:0] l2_wdata_o;
   logic [3:0]  l2_be_o;
   logic        eot_o;
`ifdef TRACER_RX_DROP_CNT_EN
   logic [15:0] drop_cnt_o;
`endif

   typedef struct {
      logic [11:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        eot;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   gnt_mode = 0;   // 0: grant low, 1: grant high, 2: random

   tracer_udma_rx_ch #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .cfg_startaddr_i  (cfg_startaddr_i),
      .cfg_size_i       (cfg_size_i),
      .cfg_datasize_i   (cfg_datasize_i),
      .cfg_continuous_i (cfg_continuous_i),
      .cfg_en_i         (cfg_en_i),
      .cfg_clr_i        (cfg_clr_i),
      .cfg_en_o         (cfg_en_o),
      .cfg_pending_o    (cfg_pending_o),
      .cfg_curr_addr_o  (cfg_curr_addr_o),
      .cfg_bytes_left_o (cfg_bytes_left_o),
      .data_i           (data_i),
      .data_valid_i     (data_valid_i),
      .data_ready_o     (data_ready_o),
      .l2_req_o         (l2_req_o),
      .l2_gnt_i         (l2_gnt_i),
      .l2_addr_o        (l2_addr_o),
      .l2_wdata_o       (l2_wdata_o),
      .l2_be_o          (l2_be_o),
`ifdef TRACER_RX_DROP_CNT_EN
      .eot_o            (eot_o),
      .drop_cnt_o       (drop_cnt_o)
`else
      .eot_o            (eot_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Grant driver, updated just after each rising edge.
   initial begin
      l2_gnt_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         case (gnt_mode)
            0:       l2_gnt_i = 1'b0;
            1:       l2_gnt_i = 1'b1;
            default: l2_gnt_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard: every write that will be granted at the next edge is checked here.
   always @(negedge clk_i) begin
      if (rst_ni && l2_req_o && l2_gnt_i) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_addr",  32'(l2_addr_o),  32'(e.addr));
            check("wr_be",    32'(l2_be_o),    32'(e.be));
            check("wr_wdata", l2_wdata_o,      e.wdata);
            check("wr_eot",   32'(eot_o),      32'(e.eot));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start(input logic [11:0] a, input logic [15:0] s, input logic [1:0] ds,
                        input logic c);
      cfg_startaddr_i  = a;
      cfg_size_i       = s;
      cfg_datasize_i   = ds;
      cfg_continuous_i = c;
      cfg_en_i         = 1'b1;
      tick();
      cfg_en_i         = 1'b0;
   endtask

   task automatic expect_wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd,
                            input logic eot);
      exp_t e;
      e.addr  = a;
      e.be    = be;
      e.wdata = wd;
      e.eot   = eot;
      exp_q.push_back(e);
   endtask

   task automatic push_beat(input logic [31:0] d);
      bit done = 1'b0;
      data_i       = d;
      data_valid_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (data_ready_o) done = 1'b1;
         tick();
         if (done) break;
      end
      data_valid_i = 1'b0;
      if (!done) check("accept_timeout", 32'(data_ready_o), 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_eot();
      bit found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (l2_req_o && l2_gnt_i && eot_o) begin
            found = 1'b1;
            break;
         end
      end
      tick();
      if (!found) check("eot_timeout", 32'(eot_o), 32'd1);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_req",   32'(l2_req_o),     32'd0);
      check("rst_ready", 32'(data_ready_o), 32'd0);
      check("rst_en",    32'(cfg_en_o),     32'd0);
      check("rst_be",    32'(l2_be_o),      32'd0);
      check("rst_eot",   32'(eot_o),        32'd0);
      check("rst_left",  32'(cfg_bytes_left_o), 32'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      check("idle_ready", 32'(data_ready_o), 32'd1);
      gnt_mode = 1;
      tick();

      // Word transfer, grant always high
      expect_wr(12'h100, 4'hF, 32'h1111_0001, 1'b0);
      expect_wr(12'h104, 4'hF, 32'h2222_0002, 1'b0);
      expect_wr(12'h108, 4'hF, 32'h3333_0003, 1'b0);
      expect_wr(12'h10C, 4'hF, 32'h4444_0004, 1'b1);
      start(12'h100, 16'd16, 2'd2, 1'b0);
      check("w_en",   32'(cfg_en_o),         32'd1);
      check("w_left", 32'(cfg_bytes_left_o), 32'd16);
      push_beat(32'h1111_0001);
      check("w_req_latency", 32'(l2_req_o), 32'd1);
      push_beat(32'h2222_0002);
      push_beat(32'h3333_0003);
      push_beat(32'h4444_0004);
      wait_drain();
      check("w_en_off", 32'(cfg_en_o),         32'd0);
      check("w_left0",  32'(cfg_bytes_left_o), 32'd0);
      check("w_addr",   32'(cfg_curr_addr_o),  32'h110);

      // Start coincident with the last grant is taken on that same edge
      expect_wr(12'h300, 4'hF, 32'hA5A5_0001, 1'b1);
      expect_wr(12'h310, 4'hF, 32'hA5A5_0002, 1'b1);
      start(12'h300, 16'd4, 2'd2, 1'b0);
      push_beat(32'hA5A5_0001);
      start(12'h310, 16'd4, 2'd2, 1'b0);
      check("co_en",      32'(cfg_en_o),        32'd1);
      check("co_addr",    32'(cfg_curr_addr_o), 32'h310);
      check("co_pending", 32'(cfg_pending_o),   32'd0);
      push_beat(32'hA5A5_0002);
      wait_drain();

      // Byte transfer crossing a word boundary
      expect_wr(12'h000, 4'h8, 32'hABAB_ABAB, 1'b0);
      expect_wr(12'h004, 4'h1, 32'hCDCD_CDCD, 1'b0);
      expect_wr(12'h004, 4'h2, 32'hEFEF_EFEF, 1'b1);
      start(12'h003, 16'd3, 2'd0, 1'b0);
      push_beat(32'h1234_56AB);
      push_beat(32'h0000_00CD);
      push_beat(32'hFFFF_FFEF);
      wait_drain();
      check("b_addr", 32'(cfg_curr_addr_o), 32'h006);
      check("b_en",   32'(cfg_en_o),        32'd0);

      // Half-word transfer
      expect_wr(12'h000, 4'hC, 32'h1234_1234, 1'b0);
      expect_wr(12'h004, 4'h3, 32'h5678_5678, 1'b1);
      start(12'h002, 16'd4, 2'd1, 1'b0);
      push_beat(32'hAAAA_1234);
      push_beat(32'h0000_5678);
      wait_drain();
      check("h_addr", 32'(cfg_curr_addr_o), 32'h006);

      // Random stalls with a queued transfer; a third start while pending is ignored
      gnt_mode = 2;
      expect_wr(12'h040, 4'hF, 32'hB000_0001, 1'b0);
      expect_wr(12'h044, 4'hF, 32'hB000_0002, 1'b0);
      expect_wr(12'h048, 4'hF, 32'hB000_0003, 1'b1);
      expect_wr(12'h200, 4'hF, 32'hB000_0004, 1'b0);
      expect_wr(12'h204, 4'hF, 32'hB000_0005, 1'b1);
      start(12'h040, 16'd12, 2'd2, 1'b0);
      push_beat(32'hB000_0001);
      start(12'h200, 16'd8, 2'd2, 1'b0);
      check("p_pending", 32'(cfg_pending_o), 32'd1);
      start(12'h300, 16'd4, 2'd0, 1'b0);
      check("p_pending_hold", 32'(cfg_pending_o), 32'd1);
      push_beat(32'hB000_0002);
      push_beat(32'hB000_0003);
      wait_eot();
      check("p_en_kept", 32'(cfg_en_o),         32'd1);
      check("p_addr",    32'(cfg_curr_addr_o),  32'h200);
      check("p_left",    32'(cfg_bytes_left_o), 32'd8);
      check("p_cleared", 32'(cfg_pending_o),    32'd0);
      push_beat(32'hB000_0004);
      push_beat(32'hB000_0005);
      wait_drain();
      tick();
      check("p_addr_end", 32'(cfg_curr_addr_o), 32'h208);
      check("p_en_off",   32'(cfg_en_o),        32'd0);

      // Continuous re-arm near the top of the address space
      gnt_mode = 1;
      tick();
      expect_wr(12'hFF8, 4'hF, 32'hC000_0001, 1'b0);
      expect_wr(12'hFFC, 4'hF, 32'hC000_0002, 1'b1);
      expect_wr(12'hFF8, 4'hF, 32'hC000_0003, 1'b0);
      expect_wr(12'hFFC, 4'hF, 32'hC000_0004, 1'b1);
      start(12'hFF8, 16'd8, 2'd2, 1'b1);
      push_beat(32'hC000_0001);
      push_beat(32'hC000_0002);
      wait_eot();
      check("c_reload1", 32'(cfg_curr_addr_o),  32'hFF8);
      check("c_left1",   32'(cfg_bytes_left_o), 32'd8);
      check("c_en1",     32'(cfg_en_o),         32'd1);
      push_beat(32'hC000_0003);
      push_beat(32'hC000_0004);
      wait_eot();
      check("c_reload2", 32'(cfg_curr_addr_o), 32'hFF8);
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
      check("c_clr_en",   32'(cfg_en_o),         32'd0);
      check("c_clr_left", 32'(cfg_bytes_left_o), 32'd0);
      check("c_clr_addr", 32'(cfg_curr_addr_o),  32'hFF8);

      // Address wrap
      expect_wr(12'hFFC, 4'hF, 32'hD000_0001, 1'b1);
      start(12'hFFC, 16'd4, 2'd2, 1'b0);
      push_beat(32'hD000_0001);
      wait_drain();
      check("wrap_addr", 32'(cfg_curr_addr_o), 32'h000);

      // Clear while a request is stalled
      gnt_mode = 0;
      tick();
      tick();
      expect_wr(12'h080, 4'hF, 32'h55AA_55AA, 1'b0);
      start(12'h080, 16'd8, 2'd2, 1'b0);
      push_beat(32'h55AA_55AA);
      check("d_req", 32'(l2_req_o), 32'd1);
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("d_req_held", 32'(l2_req_o),     32'd1);
         check("d_ready",    32'(data_ready_o), 32'd0);
         check("d_addr",     32'(l2_addr_o),    32'h080);
         tick();
      end
      gnt_mode = 1;
      for (int i = 0; i < 10; i++) begin
         if (!l2_req_o) break;
         tick();
      end
      check("d_req_off", 32'(l2_req_o),         32'd0);
      check("d_en",      32'(cfg_en_o),         32'd0);
      check("d_addr_kept", 32'(cfg_curr_addr_o), 32'h080);
      check("d_left",    32'(cfg_bytes_left_o), 32'd0);
      check("d_sb_empty", 32'(exp_q.size()),    32'd0);

      // Clear and start together: clear wins
      cfg_clr_i = 1'b1;
      start(12'h0A0, 16'd8, 2'd2, 1'b0);
      cfg_clr_i = 1'b0;
      tick();
      check("ce_en",   32'(cfg_en_o),        32'd0);
      check("ce_addr", 32'(cfg_curr_addr_o), 32'h080);

      // Beats offered while idle are discarded without stalling
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
`ifdef TRACER_RX_DROP_CNT_EN
      check("drop_zero", 32'(drop_cnt_o), 32'd0);
`endif
      data_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("idle_ready_beat", 32'(data_ready_o), 32'd1);
         tick();
      end
      data_valid_i = 1'b0;
      check("idle_no_req", 32'(l2_req_o), 32'd0);
`ifdef TRACER_RX_DROP_CNT_EN
      check("drop_five", 32'(drop_cnt_o), 32'd5);
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
      check("drop_clr", 32'(drop_cnt_o), 32'd0);
      data_valid_i = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      data_valid_i = 1'b0;
      check("drop_sat", 32'(drop_cnt_o), 32'hFFFF);
`endif

      // Reset in the middle of a stalled transfer
      gnt_mode = 0;
      tick();
      tick();
      start(12'h120, 16'd8, 2'd2, 1'b0);
      push_beat(32'hEEEE_0001);
      check("r_req", 32'(l2_req_o), 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      check("r_req_drop", 32'(l2_req_o),        32'd0);
      check("r_en",       32'(cfg_en_o),        32'd0);
      check("r_addr",     32'(cfg_curr_addr_o), 32'h000);
      tick();
      rst_ni = 1'b1;
      tick();
      check("end_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
